// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Scoreboard entry layout, FSM states and forwarding-select codes.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam int SB_W = $bits(sb_entry_t);

    // A load still in EX cannot forward; that case stalls instead.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic       used,
        input sb_entry_t  ex,
        input sb_entry_t  mem,
        input sb_entry_t  wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && src != 5'd0) begin
            if (ex.valid && !ex.is_load && ex.rd == src)
                sel = FWD_EXE;
            else if (mem.valid && mem.rd == src)
                sel = FWD_MEM;
            else if (wb.valid && wb.rd == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_run_ctrl.sv
// RUN/HALT/STEP debug sequencer.
// STEP lasts until one ID instruction actually issues.
import hazard_ctrl_pkg::*;

module hazard_ctrl_run_ctrl #(
    parameter bit START_HALTED = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic halt_req,
    input  logic run_req,
    input  logic step_req,
    input  logic load_use,
    input  logic br_taken_ex,
    output logic halted,
    output logic not_run,
    output logic step_issue
);

    localparam state_t RST_ST = START_HALTED ? ST_HALT : ST_RUN;

    state_t state;

    assign not_run    = (state != ST_RUN);
    assign step_issue = (state == ST_STEP) && !load_use && !br_taken_ex;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= RST_ST;
            halted <= START_HALTED;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (run_req) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end else if (step_req) begin
                        state  <= ST_STEP;
                        halted <= 1'b0;
                    end
                end
                ST_STEP: begin
                    if (step_issue) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes, EXE forwarding
// selects, debug run control and stall/flush performance counters.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter bit START_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             alu_src1_is_pc_id,
    input  logic             alu_src2_is_imm_id,
    input  logic             dm_w_en_id,
    input  logic [4:0]       rd_id,
    input  logic             reg_w_en_id,
    input  logic             dm_r_en_id,
    input  logic             br_taken_ex,
    input  logic             halt_req,
    input  logic             run_req,
    input  logic             step_req,
    output logic             stallF,
    output logic             bubbleD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    sb_entry_t sb_ex, sb_mem, sb_wb, ex_next;
    logic      rs_used, rt_used, load_use, insert_bubble;
    logic      not_run, step_issue;

    assign rs_used = !alu_src1_is_pc_id;
    assign rt_used = !alu_src2_is_imm_id || dm_w_en_id;

    // Valid entries never carry rd=0, so x0 cannot match.
    assign load_use = sb_ex.valid && sb_ex.is_load &&
                      ((rs_used && rs_id == sb_ex.rd) ||
                       (rt_used && rt_id == sb_ex.rd));

    assign insert_bubble = load_use || br_taken_ex || (not_run && !step_issue);

    hazard_ctrl_run_ctrl #(
        .START_HALTED(START_HALTED)
    ) u_run_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .halt_req   (halt_req),
        .run_req    (run_req),
        .step_req   (step_req),
        .load_use   (load_use),
        .br_taken_ex(br_taken_ex),
        .halted     (halted),
        .not_run    (not_run),
        .step_issue (step_issue)
    );

    always_comb begin
        ex_next = '0;
        if (!insert_bubble) begin
            ex_next.valid   = reg_w_en_id && (rd_id != 5'd0);
            ex_next.rd      = rd_id;
            ex_next.is_load = dm_r_en_id;
        end
    end

    // Branch redirect wins over both load-use and the HALT hold.
    always_comb begin
        stallF  = 1'b0;
        bubbleD = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        if (br_taken_ex) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use || halted) begin
            stallF  = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_ex  <= ex_next;
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
        end
    end

    // Selects travel with the ID->EXE register, so a flushed slot gets 00.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (flushE) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= fwd_pick(rs_id, rs_used, sb_ex, sb_mem, sb_wb);
            fwd_b_sel <= fwd_pick(rt_id, rt_used, sb_ex, sb_mem, sb_wb);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (load_use && !br_taken_ex)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (br_taken_ex)
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table for the
// pipeline hazards, plus hand sequences for halt/step and async reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic        alu_src1_is_pc_id, alu_src2_is_imm_id, dm_w_en_id;
    logic        reg_w_en_id, dm_r_en_id, br_taken_ex;
    logic        halt_req, run_req, step_req;
    logic        stallF, bubbleD, flushD, flushE, halted;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [3:0]  ctl;

    int errors = 0;
    int checks = 0;
    int issued;

    assign ctl = {stallF, bubbleD, flushD, flushE};

    always #5 clk = ~clk;

    hazard_ctrl #(
        .CNT_W       (32),
        .START_HALTED(1'b0)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .rs_id             (rs_id),
        .rt_id             (rt_id),
        .alu_src1_is_pc_id (alu_src1_is_pc_id),
        .alu_src2_is_imm_id(alu_src2_is_imm_id),
        .dm_w_en_id        (dm_w_en_id),
        .rd_id             (rd_id),
        .reg_w_en_id       (reg_w_en_id),
        .dm_r_en_id        (dm_r_en_id),
        .br_taken_ex       (br_taken_ex),
        .halt_req          (halt_req),
        .run_req           (run_req),
        .step_req          (step_req),
        .stallF            (stallF),
        .bubbleD           (bubbleD),
        .flushD            (flushD),
        .flushE            (flushE),
        .fwd_a_sel         (fwd_a_sel),
        .fwd_b_sel         (fwd_b_sel),
        .halted            (halted),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
    );

    // ctl = {stallF, bubbleD, flushD, flushE}; fa/fb are the selects
    // visible during that cycle (set by the previous ID instruction).
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       pc1;
        logic       imm;
        logic       st;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       br;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input int rs, rt, pc1, imm, st, rd,
                                input int we, ld, br, c, fa, fb);
        vec_t v;
        v.rs  = 5'(rs);
        v.rt  = 5'(rt);
        v.pc1 = 1'(pc1);
        v.imm = 1'(imm);
        v.st  = 1'(st);
        v.rd  = 5'(rd);
        v.we  = 1'(we);
        v.ld  = 1'(ld);
        v.br  = 1'(br);
        v.ctl = 4'(c);
        v.fa  = 2'(fa);
        v.fb  = 2'(fb);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_id(input int rs, rt, pc1, imm, st, rd, we, ld);
        rs_id              = 5'(rs);
        rt_id              = 5'(rt);
        alu_src1_is_pc_id  = 1'(pc1);
        alu_src2_is_imm_id = 1'(imm);
        dm_w_en_id         = 1'(st);
        rd_id              = 5'(rd);
        reg_w_en_id        = 1'(we);
        dm_r_en_id         = 1'(ld);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rs rt pc im st rd we ld br ctl     fa fb
        tbl[0]  = mk(1, 0, 0, 1, 0, 5, 1, 1, 0, 'b0000, 0, 0);
        tbl[1]  = mk(5, 1, 0, 0, 0, 6, 1, 0, 0, 'b1101, 0, 0);
        tbl[2]  = mk(5, 1, 0, 0, 0, 6, 1, 0, 0, 'b0000, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0);
        tbl[5]  = mk(1, 2, 0, 0, 0, 5, 1, 0, 0, 'b0000, 0, 0);
        tbl[6]  = mk(5, 5, 0, 0, 0, 7, 1, 0, 0, 'b0000, 0, 0);
        tbl[7]  = mk(7, 0, 0, 0, 0, 5, 1, 0, 0, 'b0000, 1, 1);
        tbl[8]  = mk(7, 5, 0, 1, 1, 0, 0, 0, 0, 'b0000, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 2, 1);
        tbl[10] = mk(5, 9, 0, 0, 0, 8, 1, 0, 0, 'b0000, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 3, 0);
        tbl[12] = mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 'b0000, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 6, 1, 0, 0, 'b0000, 0, 0);
        tbl[14] = mk(1, 0, 0, 1, 0, 9, 1, 1, 0, 'b0000, 0, 0);
        tbl[15] = mk(5, 9, 0, 1, 0, 5, 1, 0, 0, 'b0000, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0);
        tbl[17] = mk(5, 0, 1, 1, 0, 1, 1, 0, 0, 'b0000, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0);
        tbl[19] = mk(2, 0, 0, 1, 0, 5, 1, 1, 0, 'b0000, 0, 0);
        tbl[20] = mk(5, 2, 0, 0, 0, 6, 1, 0, 1, 'b0011, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0);

        rstn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        br_taken_ex = 1'b0;
        halt_req    = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        #1;
        chk("reset_ctl", 32'(ctl), 32'd0);
        chk("reset_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_cnts", 32'(perf_stall_cnt | perf_flush_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            set_id(int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].pc1),
                   int'(tbl[i].imm), int'(tbl[i].st), int'(tbl[i].rd),
                   int'(tbl[i].we), int'(tbl[i].ld));
            br_taken_ex = tbl[i].br;
            @(negedge clk);
            chk($sformatf("row%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
            chk($sformatf("row%0d_fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].fa));
            chk($sformatf("row%0d_fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].fb));
            tick();
        end
        br_taken_ex = 1'b0;
        chk("stall_cnt_after_table", perf_stall_cnt, 32'd1);
        chk("flush_cnt_after_table", perf_flush_cnt, 32'd1);

        // Halt for three cycles, then a single step.
        set_id(1, 2, 0, 0, 0, 10, 1, 0);
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt_req_cycle_ctl", 32'(ctl), 32'd0);
        chk("halt_req_cycle_halted", 32'(halted), 32'd0);
        tick();
        halt_req = 1'b0;
        issued = 0;
        repeat (3) begin
            @(negedge clk);
            chk("halt_hold_ctl", 32'(ctl), 32'b1101);
            chk("halt_hold_halted", 32'(halted), 32'd1);
            if (!bubbleD && !flushE) issued++;
            tick();
        end
        step_req = 1'b1;
        @(negedge clk);
        chk("step_req_cycle_ctl", 32'(ctl), 32'b1101);
        if (!bubbleD && !flushE) issued++;
        tick();
        step_req = 1'b0;
        @(negedge clk);
        chk("step_cycle_halted", 32'(halted), 32'd0);
        chk("step_cycle_ctl", 32'(ctl), 32'd0);
        if (!bubbleD && !flushE) issued++;
        tick();
        repeat (2) begin
            @(negedge clk);
            chk("after_step_halted", 32'(halted), 32'd1);
            if (!bubbleD && !flushE) issued++;
            tick();
        end
        chk("step_issue_count", 32'(issued), 32'd1);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        @(negedge clk);
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_ctl", 32'(ctl), 32'd0);
        tick();

        // lw issues as HALT is taken; step is killed by a branch flush.
        set_id(1, 0, 0, 1, 0, 5, 1, 1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step_req = 1'b1;
        @(negedge clk);
        chk("f_halt_halted", 32'(halted), 32'd1);
        chk("f_halt_ctl", 32'(ctl), 32'b1101);
        tick();
        step_req = 1'b0;
        br_taken_ex = 1'b1;
        @(negedge clk);
        chk("f_step_br_halted", 32'(halted), 32'd0);
        chk("f_step_br_ctl", 32'(ctl), 32'b0011);
        tick();
        br_taken_ex = 1'b0;
        @(negedge clk);
        chk("f_step_kept", 32'(halted), 32'd0);
        chk("f_flush_cnt", perf_flush_cnt, 32'd2);
        chk("f_stall_cnt", perf_stall_cnt, 32'd1);

        rstn = 1'b0;
        #1;
        chk("midrst_ctl", 32'(ctl), 32'd0);
        chk("midrst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        chk("midrst_stall_cnt", perf_stall_cnt, 32'd0);
        chk("midrst_flush_cnt", perf_flush_cnt, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        set_id(5, 1, 0, 0, 0, 6, 1, 0);
        #1;
        chk("post_rst_ctl", 32'(ctl), 32'd0);
        tick();
        @(negedge clk);
        chk("post_rst_halted", 32'(halted), 32'd0);
        chk("post_rst_fwd_a", 32'(fwd_a_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
